// File: rtl/max_seq.sv
// Streaming maximum finder: walks M unsigned values through one shared comparator
// and reports the largest value plus the index where it first appeared.

module nat_cmp #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         less
);

  logic [N:0] carry;

  // x + ~y + 1 carries out exactly when x >= y, so only the carry chain is built.
  always_comb begin
    carry[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      carry[i+1] = (x[i] & ~y[i]) | ((x[i] ^ ~y[i]) & carry[i]);
    end
  end

  assign less = ~carry[N];

endmodule

module max_seq #(
  parameter  int N  = 8,
  parameter  int M  = 4,
  localparam int IW = $clog2(M)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  x,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  max,
  output logic [IW-1:0] idx
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RUN,
    DONE
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(M - 1);

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] count;
  logic [IW-1:0] count_d;
  logic [N-1:0]  max_d;
  logic [IW-1:0] idx_d;
  logic          accept;
  logic          less;

  nat_cmp #(.N(N)) u_cmp (
    .x    (max),
    .y    (x),
    .less (less)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count   <= '0;
      max     <= '0;
      idx     <= '0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      max     <= max_d;
      idx     <= idx_d;
    end
  end

  // in_ready depends on state alone; accept is the only place in_valid matters.
  always_comb begin
    state_d  = state_q;
    count_d  = count;
    max_d    = max;
    idx_d    = idx;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FIRST;
          count_d = '0;
        end
      end
      FIRST: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (accept) begin
          max_d   = x;
          idx_d   = '0;
          count_d = IW'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (accept) begin
          // Strict less-than keeps the earliest index on ties.
          if (less) begin
            max_d = x;
            idx_d = count;
          end
          if (count == LAST) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count + IW'(1);
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = FIRST;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_max_seq.sv
// Scoreboard bench for max_seq: stimulus pushes hand-computed results, a monitor
// pops and compares them whenever done rises.

module tb_max_seq;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  x;
  logic          in_valid;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic [N-1:0]  max;
  logic [IW-1:0] idx;

  int tests = 0;
  int fails = 0;

  logic [N+IW-1:0] sb_q[$];
  logic [N+IW-1:0] exp_e;
  logic            done_seen = 1'b0;

  always #5 clock = ~clock;

  max_seq #(.N(N), .M(M)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max      (max),
    .idx      (idx)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; raises start for one edge and checks the FIRST state.
  task automatic startRun(input bit with_valid, input logic [N-1:0] junk,
                          input logic [N-1:0] pmax, input logic [IW-1:0] pidx);
    start    = 1'b1;
    in_valid = with_valid;
    x        = junk;
    @(negedge clock);
    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput("first_in_ready", in_ready, 1);
    checkOutput("first_busy", busy, 1);
    checkOutput("first_done", done, 0);
    checkOutput("first_max_kept", max, pmax);
    checkOutput("first_idx_kept", idx, pidx);
  endtask

  // Feeds M values (vals[M-1] first) with optional idle gaps and a stray start.
  task automatic applyStimulus(input logic [M-1:0][N-1:0] vals, input int gap, input bit stray,
                               input logic [N-1:0] emax, input logic [IW-1:0] eidx);
    int waited;
    sb_q.push_back({emax, eidx});
    for (int i = 0; i < M; i++) begin
      x        = vals[M-1-i];
      in_valid = 1'b1;
      start    = stray && (i == 1);
      waited   = 0;
      while (!in_ready && waited < 20) begin
        @(negedge clock);
        waited++;
      end
      if (!in_ready) checkOutput("accept_timeout", 0, 1);
      @(negedge clock);
      start = 1'b0;
      if (i < M - 1) begin
        checkOutput("done_early", done, 0);
        if (gap > 0) begin
          in_valid = 1'b0;
          x        = '1;
          repeat (gap) @(negedge clock);
          checkOutput("stall_busy", busy, 1);
        end
      end
    end
    in_valid = 1'b0;
    checkOutput("done_latency", done, 1);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_in_ready", in_ready, 0);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (done && !done_seen) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_done", 1, 0);
        end else begin
          exp_e = sb_q.pop_front();
          checkOutput("sb_max", max, exp_e[N+IW-1:IW]);
          checkOutput("sb_idx", idx, exp_e[IW-1:0]);
        end
      end
      done_seen = done;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_max", max, 0);
    checkOutput("reset_idx", idx, 0);
    reset = 1'b0;

    // Reset in the middle of a run discards the partial result.
    startRun(0, 8'd0, 8'd0, 2'd0);
    x = 8'd7; in_valid = 1'b1;
    @(negedge clock);
    x = 8'd9;
    @(negedge clock);
    in_valid = 1'b0;
    checkOutput("midrun_busy", busy, 1);
    checkOutput("midrun_max", max, 9);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midreset_in_ready", in_ready, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_max", max, 0);
    checkOutput("midreset_idx", idx, 0);

    startRun(1, 8'd200, 8'd0, 2'd0);
    applyStimulus({8'd3, 8'd10, 8'd20, 8'd255}, 0, 0, 8'd255, 2'd3);

    startRun(0, 8'd0, 8'd255, 2'd3);
    applyStimulus({8'd200, 8'd100, 8'd50, 8'd0}, 0, 0, 8'd200, 2'd0);

    startRun(0, 8'd0, 8'd200, 2'd0);
    applyStimulus({8'd0, 8'd0, 8'd0, 8'd0}, 0, 0, 8'd0, 2'd0);

    startRun(0, 8'd0, 8'd0, 2'd0);
    applyStimulus({8'd5, 8'd9, 8'd9, 8'd9}, 2, 0, 8'd9, 2'd1);

    startRun(1, 8'd77, 8'd9, 2'd1);
    applyStimulus({8'd1, 8'd2, 8'd3, 8'd4}, 0, 1, 8'd4, 2'd3);

    repeat (3) @(negedge clock);
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/max_seq.md
Name: max_seq

Overview:
- Sequential maximum-finder over a stream of M naturals of N bits each.
- Sequences one shared nat_cmp comparator across the stream instead of a comparator tree.
- Reports the maximum value and the index of its first occurrence.
- Sits between a producer with a valid/ready interface and any consumer that reads the result after done.

Parameters:
- N, 8, operand width in bits (natural, unsigned).
- M, 4, number of values per run; M >= 2.
- IW, $clog2(M), width of index and counter fields; derived, not overridden.

Ports:
- clock  input  1  sole clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begins a run; sampled in IDLE or DONE only.
- x  input  N  data value offered by the producer.
- in_valid  input  1  x is valid this cycle.
- in_ready  output  1  block accepts x this cycle.
- busy  output  1  run in progress.
- done  output  1  max/idx valid; held until the next run starts.
- max  output  N  largest value of the completed run.
- idx  output  IW  position (0..M-1) of the first occurrence of max.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, taking effect on the rising clock edge where reset=1.
- Reset state: IDLE. Outputs in reset: in_ready=0, busy=0, done=0, max=0, idx=0. Internal count=0.
- Reset overrides all other inputs, including mid-run; the partial run is discarded.
- Handshake: a value is accepted on a rising edge where in_valid=1 and in_ready=1.
- in_ready is 1 only in states FIRST and RUN. It is combinational from state only and never depends on in_valid.
- Comparator: exactly one nat_cmp instance with x-input = max register, y-input = x port. Its less output drives the update decision. No other magnitude comparison is present.

State machine:
- IDLE: busy=0, done=0. start=1 -> FIRST, count<=0.
- FIRST:
  - busy=1.
  - On accept: max<=x, idx<=0, count<=1, -> RUN. The first value is loaded unconditionally, with no comparison.
- RUN:
  - busy=1.
  - On accept: if less=1 (max < x, strict), then max<=x and idx<=count. Otherwise max and idx are unchanged.
  - Ties keep the earlier index.
  - count<=count+1.
  - On accepting the value with count==M-1: -> DONE.
- DONE:
  - busy=0, done=1. max and idx are stable.
  - start=1 -> FIRST. done drops to 0 in the same edge; max and idx keep their old values until the first new accept.
- start is ignored in FIRST and RUN.
- in_valid is ignored when in_ready=0.

Timing:
- Latency: done=1 on the cycle after the edge that accepted the M-th value.
- Back-to-back accepts at one per cycle are supported; a minimum run takes M cycles after the start edge, plus 1 cycle to done.
- Gaps (in_valid=0) stall the run indefinitely without changing any state.

Arithmetic:
- All values are unsigned. max=0 is legal data, so a run of all zeros returns max=0, idx=0.
- Maximum value 2^N-1 is handled with no overflow: the comparison uses the adder carry, not the sum.
- count wraps only by leaving RUN; it never reaches M.

Simultaneous events:
- start and in_valid together in IDLE: only start acts; x is not accepted, because in_ready=0 in IDLE.
- start=1 in DONE with in_valid=1: x is not accepted that cycle.

Test Plan:
- Reset mid-run: start, accept 7 and 9, then reset=1 for one cycle -> next cycle state IDLE, busy=0, done=0, max=0, idx=0, in_ready=0.
- Ascending stream 3,10,20,255 (N=8, M=4), in_valid held high -> accepts on 4 consecutive edges; next cycle done=1, max=255, idx=3, busy=0.
- Descending stream 200,100,50,0 -> max=200, idx=0. Verifies the first-value load and no update on less=0.
- Ties 5,9,9,9 with gaps of 2 idle cycles between values -> max=9, idx=1. Stall cycles leave count, max and idx unchanged; done only after the 4th accept.
- All zeros 0,0,0,0 -> max=0, idx=0, done=1.
- Restart and stray start: in DONE with max=9, raise start -> done=0 next cycle, in_ready=1. Then send 1,2,3,4 -> max=4, idx=3. A start pulse asserted during RUN has no effect.
